// File: rtl/lna_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lna_ctrl
//  Description : Multi-channel LNA control block on the CPU bus. Each channel
//                has a power-down output, a mode word, a power-up settling
//                FSM with programmable settle time, a settled flag and a
//                sticky settled-event interrupt bit.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module lna_ctrl #(
    parameter int N_CH       = 2,
    parameter int MODE_W     = 3,
    parameter int SETTLE_W   = 16,
    parameter int SETTLE_RST = 100,
    parameter int ADDR_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic [ADDR_W-1:0]      address,
    input  logic [31:0]            wdata,
    input  logic                   wstrb,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [N_CH-1:0]        pd,
    output logic [N_CH*MODE_W-1:0] mode,
    output logic [N_CH-1:0]        rf_rdy,
    output logic                   irq
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_SETTLING = 2'd1,
        ST_ON       = 2'd2
    } state_t;

    localparam logic [SETTLE_W-1:0] c_SETTLE_RST = SETTLE_W'(SETTLE_RST);
    localparam logic [SETTLE_W-1:0] c_SETTLE_ONE = SETTLE_W'(1);

    logic                r_ready;
    logic [31:0]         r_rdata;
    logic [N_CH-1:0]     r_ctrl;
    logic [N_CH-1:0]     r_pend;
    logic                r_irq;
    logic [SETTLE_W-1:0] r_settle;

    logic                w_acc;
    logic                w_wr;
    logic                w_ctrl_we;
    logic                w_settle_we;
    logic                w_pend_we;
    logic [N_CH-1:0]     w_pend_set;
    logic [N_CH-1:0]     w_pend_nxt;
    logic [N_CH-1:0]     w_settling;
    logic [N_CH-1:0]     w_on;
    logic [SETTLE_W-1:0] w_reload;
    logic [31:0]         w_rdata;

    // An access is taken only while ready is low, so every request gets one ack pulse
    assign w_acc       = valid & ~r_ready;
    assign w_wr        = w_acc & wstrb;
    assign w_ctrl_we   = w_wr && (address == ADDR_W'(0));
    assign w_settle_we = w_wr && (address == ADDR_W'(2));
    assign w_pend_we   = w_wr && (address == ADDR_W'(3));

    // A settle time of zero still needs one cycle in SETTLING
    assign w_reload = (r_settle == '0) ? c_SETTLE_ONE : r_settle;

    // New FSM settle events win over a simultaneous write-one-to-clear
    assign w_pend_nxt = (r_pend & ~(w_pend_we ? wdata[N_CH-1:0] : '0)) | w_pend_set;

    assign ready = r_ready;
    assign rdata = r_rdata;
    assign irq   = r_irq;

    // Register read mux; unmapped addresses and unused bits read zero
    always_comb begin
        w_rdata = '0;
        if (address == ADDR_W'(0)) begin
            w_rdata[N_CH-1:0] = r_ctrl;
        end else if (address == ADDR_W'(1)) begin
            w_rdata[N_CH-1:0]  = w_on;
            w_rdata[16 +: N_CH] = w_settling;
        end else if (address == ADDR_W'(2)) begin
            w_rdata[SETTLE_W-1:0] = r_settle;
        end else if (address == ADDR_W'(3)) begin
            w_rdata[N_CH-1:0] = r_pend;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (address == ADDR_W'(4 + i)) begin
                    w_rdata[MODE_W-1:0] = mode[i*MODE_W +: MODE_W];
                end
            end
        end
    end

    // Bus handshake and shared control/status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_ctrl   <= '0;
            r_settle <= c_SETTLE_RST;
            r_pend   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_ready <= w_acc;
            if (w_acc) begin
                r_rdata <= w_rdata;
            end
            if (w_ctrl_we) begin
                r_ctrl <= wdata[N_CH-1:0];
            end
            if (w_settle_we) begin
                r_settle <= wdata[SETTLE_W-1:0];
            end
            r_pend <= w_pend_nxt;
            r_irq  <= |w_pend_nxt;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t              r_state;
        state_t              w_state_nxt;
        logic [SETTLE_W-1:0] r_cnt;
        logic [SETTLE_W-1:0] w_cnt_nxt;
        logic [MODE_W-1:0]   r_mode;
        logic                r_mode_upd;
        logic                w_mode_we;
        logic                w_set;

        assign w_mode_we = w_wr && (address == ADDR_W'(4 + gi));

        // Mode word plus a one-cycle flag telling the FSM it was rewritten
        always_ff @(posedge clk) begin
            if (rst) begin
                r_mode     <= '0;
                r_mode_upd <= 1'b0;
            end else begin
                r_mode_upd <= w_mode_we;
                if (w_mode_we) begin
                    r_mode <= wdata[MODE_W-1:0];
                end
            end
        end

        // Settling FSM next state: disable has priority over completion and reload
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_set       = 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (r_ctrl[gi]) begin
                        w_state_nxt = ST_SETTLING;
                        w_cnt_nxt   = w_reload;
                    end
                end
                ST_SETTLING: begin
                    if (!r_ctrl[gi]) begin
                        w_state_nxt = ST_OFF;
                    end else if (r_cnt == c_SETTLE_ONE) begin
                        w_state_nxt = ST_ON;
                        w_set       = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - c_SETTLE_ONE;
                    end
                end
                ST_ON: begin
                    if (!r_ctrl[gi]) begin
                        w_state_nxt = ST_OFF;
                    end else if (r_mode_upd) begin
                        w_state_nxt = ST_SETTLING;
                        w_cnt_nxt   = w_reload;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end

        // Settling FSM state and counter registers
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        assign pd[gi]         = (r_state == ST_OFF);
        assign rf_rdy[gi]     = (r_state == ST_ON);
        assign w_on[gi]       = (r_state == ST_ON);
        assign w_settling[gi] = (r_state == ST_SETTLING);
        assign w_pend_set[gi] = w_set;
        assign mode[gi*MODE_W +: MODE_W] = r_mode;
    end

endmodule
`default_nettype wire

// File: tb/tb_lna_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lna_ctrl
//  Description : Self-checking bench for lna_ctrl. A timestamp-based model
//                predicts per-channel power-up, settle completion and sticky
//                events; directed steps are followed by random bus traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lna_ctrl;

    localparam int N_CH       = 2;
    localparam int MODE_W     = 3;
    localparam int SETTLE_W   = 16;
    localparam int SETTLE_RST = 100;
    localparam int ADDR_W     = 4;
    localparam int INF        = 32'h3fff_ffff;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   valid = 1'b0;
    logic [ADDR_W-1:0]      address = '0;
    logic [31:0]            wdata = '0;
    logic                   wstrb = 1'b0;
    logic [31:0]            rdata;
    logic                   ready;
    logic [N_CH-1:0]        pd;
    logic [N_CH*MODE_W-1:0] mode;
    logic [N_CH-1:0]        rf_rdy;
    logic                   irq;

    lna_ctrl #(
        .N_CH(N_CH), .MODE_W(MODE_W), .SETTLE_W(SETTLE_W),
        .SETTLE_RST(SETTLE_RST), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .pd(pd), .mode(mode),
        .rf_rdy(rf_rdy), .irq(irq)
    );

    always #5 clk = ~clk;

    // Edge counter: a sample taken at the negedge after edge k sees cyc == k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model (event timestamps per channel) --------
    int              m_start [N_CH];  // edge after which pd is low
    int              m_on    [N_CH];  // edge after which rf_rdy is high
    int              m_off   [N_CH];  // edge after which the channel is off again
    int              m_evt   [N_CH];  // edge at which a settled event sets PEND
    bit              m_evtv  [N_CH];
    logic [MODE_W-1:0] m_mode[N_CH];
    bit   [N_CH-1:0] m_pend;
    bit   [N_CH-1:0] m_ctrl;
    int              m_settle;

    function automatic void m_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_start[i] = INF; m_on[i] = INF; m_off[i] = INF;
            m_evt[i] = INF; m_evtv[i] = 1'b0; m_mode[i] = '0;
        end
        m_pend = '0; m_ctrl = '0; m_settle = SETTLE_RST;
    endfunction

    function automatic int sdur();
        return (m_settle == 0) ? 1 : m_settle;
    endfunction

    function automatic bit m_pd(input int i, input int t);
        return !(t >= m_start[i] && t < m_off[i]);
    endfunction

    function automatic bit m_rdy(input int i, input int t);
        return (t >= m_start[i] && t >= m_on[i] && t < m_off[i]);
    endfunction

    function automatic bit m_settling(input int i, input int t);
        return (t >= m_start[i] && t < m_on[i] && t < m_off[i]);
    endfunction

    function automatic bit m_pnd(input int i, input int t);
        return m_pend[i] | (m_evtv[i] && t >= m_evt[i]);
    endfunction

    function automatic bit m_irq(input int t);
        bit r = 1'b0;
        for (int i = 0; i < N_CH; i++) r |= m_pnd(i, t);
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int a, input int t);
        logic [31:0] r;
        r = '0;
        if (a == 0) r[N_CH-1:0] = m_ctrl;
        else if (a == 1) begin
            for (int i = 0; i < N_CH; i++) begin
                r[i] = m_rdy(i, t);
                r[16+i] = m_settling(i, t);
            end
        end
        else if (a == 2) r[SETTLE_W-1:0] = SETTLE_W'(m_settle);
        else if (a == 3) begin
            for (int i = 0; i < N_CH; i++) r[i] = m_pnd(i, t);
        end
        else if (a >= 4 && a < 4 + N_CH) r[MODE_W-1:0] = m_mode[a-4];
        return r;
    endfunction

    // Apply a write accepted at edge e
    function automatic void m_write(input int a, input logic [31:0] d, input int e);
        if (a == 0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (d[i] && !m_ctrl[i]) begin
                    m_start[i] = e + 1; m_on[i] = e + 1 + sdur(); m_off[i] = INF;
                    m_evt[i] = m_on[i]; m_evtv[i] = 1'b1;
                end else if (!d[i] && m_ctrl[i]) begin
                    m_off[i] = e + 1;
                    if (m_evtv[i] && m_evt[i] <= e) m_pend[i] = 1'b1;
                    m_evtv[i] = 1'b0;
                end
            end
            m_ctrl = d[N_CH-1:0];
        end else if (a == 2) begin
            m_settle = int'(d[SETTLE_W-1:0]);
        end else if (a == 3) begin
            for (int i = 0; i < N_CH; i++) begin
                if (d[i]) begin
                    m_pend[i] = 1'b0;
                    if (m_evtv[i] && m_evt[i] < e) m_evtv[i] = 1'b0;
                end
            end
        end else if (a >= 4 && a < 4 + N_CH) begin
            m_mode[a-4] = d[MODE_W-1:0];
            if (m_ctrl[a-4] && m_rdy(a - 4, e)) begin
                if (m_evtv[a-4]) m_pend[a-4] = 1'b1;
                m_on[a-4] = e + 1 + sdur();
                m_evt[a-4] = m_on[a-4]; m_evtv[a-4] = 1'b1;
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_outs();
        logic [N_CH-1:0]        e_pd, e_rdy;
        logic [N_CH*MODE_W-1:0] e_mode;
        for (int i = 0; i < N_CH; i++) begin
            e_pd[i] = m_pd(i, cyc);
            e_rdy[i] = m_rdy(i, cyc);
            e_mode[i*MODE_W +: MODE_W] = m_mode[i];
        end
        chk("pd", 32'(pd), 32'(e_pd));
        chk("rf_rdy", 32'(rf_rdy), 32'(e_rdy));
        chk("irq", 32'(irq), 32'(m_irq(cyc)));
        chk("mode", 32'(mode), 32'(e_mode));
    endtask

    // One bus access starting at a negedge; returns at the negedge after ready falls
    task automatic access(input int a, input bit w, input logic [31:0] d,
                          output int e, output logic [31:0] rd);
        address = ADDR_W'(a); wstrb = w; wdata = d; valid = 1'b1;
        @(negedge clk);
        e = cyc;
        rd = rdata;
        chk($sformatf("ready_hi a%0d", a), 32'(ready), 32'd1);
        chk($sformatf("rdata a%0d", a), rdata, m_read(a, e - 1));
        if (w) m_write(a, d, e);
        valid = 1'b0; wstrb = 1'b0;
        @(negedge clk);
        chk("ready_lo", 32'(ready), 32'd0);
    endtask

    task automatic wait_to(input int t);
        int n = 0;
        while (cyc < t && n < 100000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e, e2, c;
        logic [31:0] rd;

        // 1: reset state
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pd", 32'(pd), 32'h3);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk_outs();
        access(2, 1'b0, 32'h0, e, rd);
        chk("rst_settle", rd, 32'd100);
        access(0, 1'b0, 32'h0, e, rd);
        chk("rst_ctrl", rd, 32'd0);

        // 2: SETTLE=4, enable ch0
        access(2, 1'b1, 32'd4, e, rd);
        access(0, 1'b1, 32'd1, e, rd);
        chk("t2_pd", 32'(pd), 32'h2);
        chk_outs();
        wait_to(e + 4);
        chk("t2_rdy_early", 32'(rf_rdy), 32'h0);
        chk("t2_irq_early", 32'(irq), 32'h0);
        wait_to(e + 5);
        chk("t2_rdy", 32'(rf_rdy), 32'h1);
        chk("t2_irq", 32'(irq), 32'h1);

        // 3: clear event, rewrite MODE[0] while ON
        access(3, 1'b1, 32'd1, e, rd);
        chk("t3_irq_clr", 32'(irq), 32'h0);
        access(4, 1'b1, 32'd5, e, rd);
        chk("t3_mode", 32'(mode[2:0]), 32'd5);
        chk("t3_rdy_drop", 32'(rf_rdy[0]), 32'd0);
        chk_outs();
        wait_to(e + 4);
        chk("t3_rdy_still_low", 32'(rf_rdy[0]), 32'd0);
        wait_to(e + 5);
        chk("t3_rdy_back", 32'(rf_rdy[0]), 32'd1);
        chk("t3_irq", 32'(irq), 32'd1);

        // 4: abort mid-settle
        access(0, 1'b1, 32'd0, e, rd);
        access(3, 1'b1, 32'd3, e, rd);
        access(0, 1'b1, 32'd1, e, rd);
        access(0, 1'b1, 32'd0, e2, rd);
        chk("t4_pd", 32'(pd), 32'h3);
        wait_to(e + 12);
        chk("t4_rdy", 32'(rf_rdy), 32'h0);
        chk_outs();
        access(3, 1'b0, 32'd0, e, rd);
        chk("t4_pend", rd, 32'd0);

        // 5: W1C on the same edge as ch1 settles
        access(0, 1'b1, 32'd1, e, rd);
        wait_to(e + 6);
        chk("t5_irq0", 32'(irq), 32'd1);
        access(0, 1'b1, 32'd3, e, rd);
        c = e + 5;
        wait_to(c - 1);
        access(3, 1'b1, 32'd1, e, rd);
        chk("t5_edge", 32'(e), 32'(c));
        access(3, 1'b0, 32'd0, e, rd);
        chk("t5_pend", rd, 32'd2);
        chk("t5_irq", 32'(irq), 32'd1);
        access(3, 1'b1, 32'd2, e, rd);
        chk("t5_irq_clr", 32'(irq), 32'd0);
        chk_outs();

        // 6: zero settle, unmapped read, RO write, back-to-back ready
        access(2, 1'b1, 32'd0, e, rd);
        access(0, 1'b1, 32'd0, e, rd);
        access(0, 1'b1, 32'd1, e, rd);
        chk("t6_pd", 32'(pd[0]), 32'd0);
        chk("t6_rdy_early", 32'(rf_rdy[0]), 32'd0);
        wait_to(e + 2);
        chk("t6_rdy", 32'(rf_rdy[0]), 32'd1);
        access(15, 1'b0, 32'd0, e, rd);
        chk("t6_unmapped", rd, 32'd0);
        access(1, 1'b1, 32'hffff_ffff, e, rd);
        access(1, 1'b0, 32'd0, e, rd);
        chk("t6_status", rd, 32'h1);
        address = ADDR_W'(15); wstrb = 1'b0; valid = 1'b1;
        @(negedge clk); chk("b2b_1", 32'(ready), 32'd1);
        @(negedge clk); chk("b2b_2", 32'(ready), 32'd0);
        @(negedge clk); chk("b2b_3", 32'(ready), 32'd1);
        valid = 1'b0;
        @(negedge clk); chk("b2b_4", 32'(ready), 32'd0);

        // Reset in the middle of settling
        access(2, 1'b1, 32'd10, e, rd);
        access(0, 1'b1, 32'd3, e, rd);
        wait_to(e + 4);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_pd", 32'(pd), 32'h3);
        chk("mrst_rdy", 32'(rf_rdy), 32'h0);
        chk("mrst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        m_reset();
        chk_outs();
        access(2, 1'b0, 32'd0, e, rd);
        chk("mrst_settle", rd, 32'd100);

        // Random traffic against the model
        access(2, 1'b1, 32'd3, e, rd);
        for (int k = 0; k < 120; k++) begin
            int op, ch, gap;
            op = int'($urandom_range(0, 5));
            ch = int'($urandom_range(0, N_CH - 1));
            case (op)
                0: access(0, 1'b1, $urandom, e, rd);
                1: access(2, 1'b1, $urandom_range(0, 6), e, rd);
                2: access(4 + ch, 1'b1, $urandom, e, rd);
                3: access(3, 1'b1, $urandom, e, rd);
                4: access(int'($urandom_range(0, 15)), 1'b0, 32'd0, e, rd);
                default: access(int'($urandom_range(0, 15)), 1'b1, $urandom & 32'h0000_0007, e, rd);
            endcase
            chk_outs();
            gap = int'($urandom_range(0, 6));
            repeat (gap) @(negedge clk);
            chk_outs();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
